// File: rtl/neopixel_rx.sv
// neopixel_rx
//   WS2812 ("NeoPixel") serial-line receiver. Measures the high time of
//   each pulse on the synchronized input to decode bits, and assembles them
//   MSB-first into 24-bit pixels. A long low period is treated as the latch
//   that ends a frame.
//
// Parameters
//   C_BIT_THRESHOLD  high clocks at/above which a bit is 1 (below: 0)
//   C_MIN_HIGH       shortest legal high time in clocks
//   C_MAX_HIGH       longest legal high time in clocks
//   C_RESET_CYCLES   low clocks that mark a latch / frame end
//
// Ports
//   clock_125m    in   sole clock
//   reset_125m_n  in   synchronous active-low reset
//   neopixel_in   in   asynchronous serial line
//   pixel_data    out  [23:0] last complete pixel, first bit received at [23]
//   pixel_valid   out  one-cycle strobe when pixel_data updates
//   pixel_index   out  [15:0] position in the frame of the pixel on pixel_data
//   frame_done    out  one-cycle strobe at latch detection
//   pixel_count   out  [15:0] complete pixels in the last finished frame
//   err           out  one-cycle protocol error strobe
//
// Build option
//   NEOPIXEL_RX_ERR_EN  when defined, out-of-range high times and latches with
//                       a partial pixel are reported on err and force a
//                       resynchronization through WAIT_RESET. When undefined,
//                       err is constant 0 and every pulse is classified only
//                       by C_BIT_THRESHOLD.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_RESET | not yet aligned to a frame; needs C_RESET_CYCLES of low
// IDLE       | aligned, line low, waiting for the first bit of a frame
// HIGH       | measuring the high part of a bit
// LOW        | measuring the low part; next bit or latch

module neopixel_rx #(
    parameter int C_BIT_THRESHOLD = 75,
    parameter int C_MIN_HIGH      = 20,
    parameter int C_MAX_HIGH      = 150,
    parameter int C_RESET_CYCLES  = 6250
) (
    input  logic        clock_125m,
    input  logic        reset_125m_n,
    input  logic        neopixel_in,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_index,
    output logic        frame_done,
    output logic [15:0] pixel_count,
    output logic        err
);

    localparam int L_HIGH_W = $clog2(C_MAX_HIGH + 2);
    localparam int L_LOW_W  = $clog2(C_RESET_CYCLES + 1);

    localparam logic [L_HIGH_W-1:0] L_HIGH_SAT = L_HIGH_W'(C_MAX_HIGH + 1);
    localparam logic [L_HIGH_W-1:0] L_THRESH   = L_HIGH_W'(C_BIT_THRESHOLD);
    localparam logic [L_HIGH_W-1:0] L_MIN_HIGH = L_HIGH_W'(C_MIN_HIGH);
    localparam logic [L_HIGH_W-1:0] L_MAX_HIGH = L_HIGH_W'(C_MAX_HIGH);
    localparam logic [L_LOW_W-1:0]  L_LOW_SAT  = L_LOW_W'(C_RESET_CYCLES);
    localparam logic [L_LOW_W-1:0]  L_LOW_HIT  = L_LOW_W'(C_RESET_CYCLES - 1);

`ifdef NEOPIXEL_RX_ERR_EN
    localparam bit L_ERR_EN = 1'b1;
`else
    localparam bit L_ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        WAIT_RESET = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } t_state;

    // Synchronizer
    logic r_sync_meta;
    logic r_sync;

    // FSM and datapath registers
    t_state              r_state;
    logic [L_HIGH_W-1:0] r_high_cnt;
    logic [L_LOW_W-1:0]  r_low_cnt;
    logic [22:0]         r_shift;
    logic [4:0]          r_bit_cnt;
    logic [15:0]         r_pix_cnt;
    logic [23:0]         r_pixel_data;
    logic [15:0]         r_pixel_index;
    logic [15:0]         r_pixel_count;
    logic                r_pixel_valid;
    logic                r_frame_done;
    logic                r_err;

    // Next-state values
    t_state              w_state_nxt;
    logic [L_HIGH_W-1:0] w_high_cnt_nxt;
    logic [L_LOW_W-1:0]  w_low_cnt_nxt;
    logic [22:0]         w_shift_nxt;
    logic [4:0]          w_bit_cnt_nxt;
    logic [15:0]         w_pix_cnt_nxt;
    logic [23:0]         w_pixel_data_nxt;
    logic [15:0]         w_pixel_index_nxt;
    logic [15:0]         w_pixel_count_nxt;
    logic                w_pixel_valid_nxt;
    logic                w_frame_done_nxt;
    logic                w_err_nxt;

    logic                w_s_in;
    logic                w_bit;
    logic [23:0]         w_word;
    logic                w_high_bad;
    logic                w_low_hit;
    logic [15:0]         w_pix_cnt_inc;

    always_ff @(posedge clock_125m) begin
        if (!reset_125m_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= neopixel_in;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_s_in = r_sync;

    // Edges are implied by the state: IDLE and LOW are only ever occupied
    // while the line was last seen low, HIGH while it was last seen high.
    assign w_bit     = (r_high_cnt >= L_THRESH);
    assign w_word    = {r_shift, w_bit};
    assign w_high_bad = L_ERR_EN && ((r_high_cnt < L_MIN_HIGH) || (r_high_cnt > L_MAX_HIGH));
    // True on the low cycle that brings the low count up to C_RESET_CYCLES.
    assign w_low_hit = !w_s_in && (r_low_cnt == L_LOW_HIT);
    assign w_pix_cnt_inc = (r_pix_cnt == 16'hFFFF) ? r_pix_cnt : r_pix_cnt + 16'd1;

    always_ff @(posedge clock_125m) begin
        if (!reset_125m_n) begin
            r_state <= WAIT_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_high_cnt_nxt    = r_high_cnt;
        w_low_cnt_nxt     = r_low_cnt;
        w_shift_nxt       = r_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_pix_cnt_nxt     = r_pix_cnt;
        w_pixel_data_nxt  = r_pixel_data;
        w_pixel_index_nxt = r_pixel_index;
        w_pixel_count_nxt = r_pixel_count;
        w_pixel_valid_nxt = 1'b0;
        w_frame_done_nxt  = 1'b0;
        w_err_nxt         = 1'b0;

        case (r_state)
            WAIT_RESET: begin
                if (w_s_in) begin
                    w_low_cnt_nxt = '0;
                end else if (w_low_hit) begin
                    w_low_cnt_nxt = L_LOW_SAT;
                    w_state_nxt   = IDLE;
                end else if (r_low_cnt != L_LOW_SAT) begin
                    w_low_cnt_nxt = r_low_cnt + L_LOW_W'(1);
                end
            end

            IDLE: begin
                w_low_cnt_nxt = '0;
                if (w_s_in) begin
                    w_high_cnt_nxt = L_HIGH_W'(1);
                    w_state_nxt    = HIGH;
                end
            end

            HIGH: begin
                if (w_s_in) begin
                    if (r_high_cnt != L_HIGH_SAT) begin
                        w_high_cnt_nxt = r_high_cnt + L_HIGH_W'(1);
                    end
                end else begin
                    // The falling-edge cycle is already the first low cycle.
                    w_low_cnt_nxt = L_LOW_W'(1);
                    if (w_high_bad) begin
                        w_err_nxt     = 1'b1;
                        w_shift_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = WAIT_RESET;
                    end else begin
                        w_state_nxt = LOW;
                        if (r_bit_cnt == 5'd23) begin
                            w_pixel_data_nxt  = w_word;
                            w_pixel_valid_nxt = 1'b1;
                            w_pixel_index_nxt = r_pix_cnt;
                            w_pix_cnt_nxt     = w_pix_cnt_inc;
                            w_shift_nxt       = '0;
                            w_bit_cnt_nxt     = '0;
                        end else begin
                            w_shift_nxt   = w_word[22:0];
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end
                    end
                end
            end

            LOW: begin
                if (w_s_in) begin
                    w_high_cnt_nxt = L_HIGH_W'(1);
                    w_state_nxt    = HIGH;
                end else if (w_low_hit) begin
                    w_low_cnt_nxt     = L_LOW_SAT;
                    w_frame_done_nxt  = 1'b1;
                    w_pixel_count_nxt = r_pix_cnt;
                    w_pix_cnt_nxt     = '0;
                    w_shift_nxt       = '0;
                    w_bit_cnt_nxt     = '0;
                    w_state_nxt       = IDLE;
                    if (L_ERR_EN && (r_bit_cnt != 5'd0)) begin
                        w_err_nxt     = 1'b1;
                        w_low_cnt_nxt = '0;
                        w_state_nxt   = WAIT_RESET;
                    end
                end else if (r_low_cnt != L_LOW_SAT) begin
                    w_low_cnt_nxt = r_low_cnt + L_LOW_W'(1);
                end
            end

            default: begin
                w_state_nxt = WAIT_RESET;
            end
        endcase
    end

    always_ff @(posedge clock_125m) begin
        if (!reset_125m_n) begin
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pix_cnt     <= '0;
            r_pixel_data  <= '0;
            r_pixel_index <= '0;
            r_pixel_count <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_high_cnt    <= w_high_cnt_nxt;
            r_low_cnt     <= w_low_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_pix_cnt     <= w_pix_cnt_nxt;
            r_pixel_data  <= w_pixel_data_nxt;
            r_pixel_index <= w_pixel_index_nxt;
            r_pixel_count <= w_pixel_count_nxt;
            r_pixel_valid <= w_pixel_valid_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign pixel_index = r_pixel_index;
    assign frame_done  = r_frame_done;
    assign pixel_count = r_pixel_count;
    assign err         = r_err;

endmodule

// File: doc/neopixel_rx.md
NEOPIXEL_RX -- requirements
Module: neopixel_rx

Interface
REQ-001 SHALL have parameter C_BIT_THRESHOLD, default 75: high-time in clocks at or above which a bit decodes as 1, below which it decodes as 0.
REQ-002 SHALL have parameter C_MIN_HIGH, default 20: minimum legal high-time in clocks.
REQ-003 SHALL have parameter C_MAX_HIGH, default 150: maximum legal high-time in clocks.
REQ-004 SHALL have parameter C_RESET_CYCLES, default 6250: low-time in clocks that marks a latch/frame end.
REQ-005 SHALL have port clock_125m, input, 1 bit: sole clock.
REQ-006 SHALL have port reset_125m_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port neopixel_in, input, 1 bit: asynchronous WS2812 serial line.
REQ-008 SHALL have port pixel_data, output, 24 bits: last complete pixel, first received bit at bit 23.
REQ-009 SHALL have port pixel_valid, output, 1 bit: one-cycle strobe when pixel_data updates.
REQ-010 SHALL have port pixel_index, output, 16 bits: index within the frame of the pixel on pixel_data.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle strobe at latch detection.
REQ-012 SHALL have port pixel_count, output, 16 bits: number of complete pixels in the last finished frame.
REQ-013 SHALL have port err, output, 1 bit: one-cycle strobe on protocol error.

Function
REQ-014 SHALL pass neopixel_in through a 2-flop synchronizer; all further timing refers to the synchronized signal (s_in).
REQ-015 SHALL implement states WAIT_RESET, IDLE, HIGH, LOW.
- WAIT_RESET: count low cycles, reset on high; go to IDLE when the count reaches C_RESET_CYCLES.
- IDLE: go to HIGH on s_in rising.
- HIGH: count high cycles; go to LOW on s_in falling.
- LOW: count low cycles; go to HIGH on rising; latch (REQ-019) when the count reaches C_RESET_CYCLES.
REQ-016 SHALL saturate the high counter at C_MAX_HIGH+1 and the low counter at C_RESET_CYCLES.
REQ-017 SHALL decode a bit at the HIGH-to-LOW transition: 1 if the high count is at least C_BIT_THRESHOLD, else 0. Bits shift in MSB-first.
REQ-018 SHALL, on the 24th bit, register pixel_data and pulse pixel_valid exactly one cycle after the s_in falling edge is detected; set pixel_index to the pixel's ordinal (0 for the first); clear the bit counter.
REQ-019 SHALL, at latch, pulse frame_done for one cycle, load pixel_count with the number of complete pixels, discard any partial bits, zero the frame pixel counter, and enter IDLE.
REQ-020 SHALL saturate the frame pixel counter at 16'hFFFF.
REQ-021 SHALL hold pixel_data, pixel_index and pixel_count between updates.
REQ-022 SHALL NOT assert pixel_valid and frame_done in the same cycle, since latch requires a low period after the last bit.

Reset
REQ-023 SHALL, while reset_125m_n is low at a clock edge, set state WAIT_RESET, all counters 0, pixel_data 0, pixel_index 0, pixel_count 0, and pixel_valid, frame_done and err 0.
REQ-024 SHALL apply reset mid-frame immediately; the partial pixel is lost and no strobe is produced.
REQ-025 SHALL clear the synchronizer flops to 0 on reset.

Configuration
REQ-026 SHALL compile pulse-width error checking in only when macro NEOPIXEL_RX_ERR_EN is defined.
REQ-027 SHALL, with NEOPIXEL_RX_ERR_EN defined, treat a high-time below C_MIN_HIGH or above C_MAX_HIGH, or a latch with 1-23 partial bits, as an error: pulse err for one cycle, discard the partial pixel, and enter WAIT_RESET. A partial-bit latch SHALL still pulse frame_done.
REQ-028 SHALL, without NEOPIXEL_RX_ERR_EN, tie err to 0 and classify every pulse only by C_BIT_THRESHOLD.

Verification
REQ-029 SHALL cover: after reset, 6250 low cycles, then a 24-bit 0xA5C3F0 stream (1 = 100 clocks high / 56 low, 0 = 50 high / 106 low) -> one pixel_valid, pixel_data=0xA5C3F0, pixel_index=0.
REQ-030 SHALL cover: 4 pixels 0x000001..0x000004, then low for 6250 clocks -> 4 pixel_valid strobes, pixel_index 0..3, then frame_done with pixel_count=4.
REQ-031 SHALL cover, with ERR_EN: a 10-clock high glitch mid-pixel -> err pulse, no pixel_valid until after the next 6250-clock low; the following pixel 0x123456 decodes correctly.
REQ-032 SHALL cover, with ERR_EN: 12 bits then a 6250-clock low -> err and frame_done, pixel_count=0.
REQ-033 SHALL cover: reset_125m_n low for 1 cycle after bit 16 -> no strobes; all outputs 0; decoding resumes only after a 6250-clock low.
REQ-034 SHALL cover: high-times of exactly 74 and 75 clocks -> decode to 0 and 1 respectively.
